// File: rtl/hazard_control_unit.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle mul/div hold, plus a saturating stall-cycle counter.
//
//   state | meaning
//   RUN   | normal issue; resolves branch / long-op entry / load-use each cycle
//   BUSY  | long op occupying EX; front of pipe held until cnt reaches 1
module hazard_control_unit #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_Rs1,
    input  logic [4:0]        IFID_Rs2,
    input  logic              IFID_UsesRs1,
    input  logic              IFID_UsesRs2,
    input  logic [4:0]        IDEX_rd,
    input  logic              IDEX_MemRead,
    input  logic              IDEX_LongOp,
    input  logic              EX_BranchTaken,
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              IDEX_Write,
    output logic              IDEX_Flush,
    output logic              EXMEM_Bubble,
    output logic              Busy,
    output logic [PERF_W-1:0] StallCycles
);

    typedef enum logic {RUN, BUSY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERF_W-1:0]   stall_q, stall_d;
    logic                load_use;

    assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                      ((IFID_UsesRs1 && (IDEX_rd == IFID_Rs1)) ||
                       (IFID_UsesRs2 && (IDEX_rd == IFID_Rs2)));

    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Flush   = 1'b0;
        EXMEM_Bubble = 1'b0;
        Busy         = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (IDEX_LongOp) begin
                        PCWrite      = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        cnt_d        = CNT_W'(MULDIV_LAT - 1);
                        state_d      = BUSY;
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFID_Write = 1'b0;
                        IDEX_Flush = 1'b1;
                    end
                end
                BUSY: begin
                    Busy = 1'b1;
                    if (cnt_q > CNT_W'(1)) begin
                        PCWrite      = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        cnt_d        = cnt_q - CNT_W'(1);
                    end else begin
                        // release cycle: result drains into EX/MEM, next op enters EX
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!PCWrite && (stall_q != {PERF_W{1'b1}}))
            stall_d = stall_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign StallCycles = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one default instance (MULDIV_LAT=4)
// and one small-counter instance (MULDIV_LAT=8, PERF_W=4) for saturation.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic        uses1, uses2, memrd, longop, br;

    logic        pcw, ifidw, ifidf, idexw, idexf, bub, busy;
    logic [15:0] stalls;

    logic        longop8;
    logic [4:0]  zero5 = 5'd0;
    logic        zero1 = 1'b0;
    logic        pcw8, ifidw8, ifidf8, idexw8, idexf8, bub8, busy8;
    logic [3:0]  stalls8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_control_unit dut (
        .clk(clk), .reset(reset),
        .IFID_Rs1(rs1), .IFID_Rs2(rs2), .IFID_UsesRs1(uses1), .IFID_UsesRs2(uses2),
        .IDEX_rd(rd), .IDEX_MemRead(memrd), .IDEX_LongOp(longop), .EX_BranchTaken(br),
        .PCWrite(pcw), .IFID_Write(ifidw), .IFID_Flush(ifidf), .IDEX_Write(idexw),
        .IDEX_Flush(idexf), .EXMEM_Bubble(bub), .Busy(busy), .StallCycles(stalls)
    );

    hazard_control_unit #(.MULDIV_LAT(8), .CNT_W(3), .PERF_W(4)) dut8 (
        .clk(clk), .reset(reset),
        .IFID_Rs1(zero5), .IFID_Rs2(zero5), .IFID_UsesRs1(zero1), .IFID_UsesRs2(zero1),
        .IDEX_rd(zero5), .IDEX_MemRead(zero1), .IDEX_LongOp(longop8), .EX_BranchTaken(zero1),
        .PCWrite(pcw8), .IFID_Write(ifidw8), .IFID_Flush(ifidf8), .IDEX_Write(idexw8),
        .IDEX_Flush(idexf8), .EXMEM_Bubble(bub8), .Busy(busy8), .StallCycles(stalls8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // packed {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, pcw, ifidw, ifidf, idexw, idexf, bub}, {26'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    localparam logic [5:0] DEF   = 6'b110100;
    localparam logic [5:0] LU    = 6'b000110;
    localparam logic [5:0] LONG  = 6'b000001;
    localparam logic [5:0] FLUSH = 6'b111110;

    initial begin
        // 1: reset with long op and branch driven
        reset = 1'b1; rs1 = 0; rs2 = 0; rd = 0; uses1 = 0; uses2 = 0;
        memrd = 0; longop = 1; br = 1; longop8 = 0;
        tick(); tick();
        chk_ctl("reset_ctl", DEF);
        chk("reset_busy", busy, 0);
        chk("reset_stalls", stalls, 0);

        reset = 0; longop = 0; br = 0;
        settle();
        chk_ctl("idle_ctl", DEF);
        tick();

        // 2: load-use on rs2
        memrd = 1; rd = 5; rs2 = 5; uses2 = 1;
        settle();
        chk_ctl("lu_rs2_stall", LU);
        tick();
        memrd = 0;
        settle();
        chk_ctl("lu_after", DEF);
        chk("lu_stalls1", stalls, 1);
        memrd = 1; rd = 0; rs2 = 0;
        settle();
        chk_ctl("lu_x0", DEF);
        rd = 5; rs2 = 5; uses2 = 0;
        settle();
        chk_ctl("lu_nouse", DEF);
        rs1 = 5; uses1 = 1;
        settle();
        chk_ctl("lu_rs1_stall", LU);
        tick();
        memrd = 0; uses1 = 0; rs1 = 0; rs2 = 0; rd = 0;
        settle();
        chk("lu_stalls2", stalls, 2);

        // 3: long op, MULDIV_LAT=4
        longop = 1;
        settle();
        chk_ctl("long_c1", LONG);
        chk("long_c1_busy", busy, 0);
        tick();
        longop = 0;
        settle();
        chk_ctl("long_c2", LONG);
        chk("long_c2_busy", busy, 1);
        tick();
        chk_ctl("long_c3", LONG);
        chk("long_c3_busy", busy, 1);
        tick();
        chk_ctl("long_c4_release", DEF);
        tick();
        chk("long_c5_busy", busy, 0);
        chk("long_stalls", stalls, 5);

        // 4: branch beats load-use and long op
        br = 1; memrd = 1; rd = 7; rs1 = 7; uses1 = 1;
        settle();
        chk_ctl("br_vs_lu", FLUSH);
        longop = 1;
        settle();
        chk_ctl("br_vs_long", FLUSH);
        tick();
        br = 0; memrd = 0; longop = 0; uses1 = 0;
        settle();
        chk("br_no_busy", busy, 0);
        chk("br_stalls", stalls, 5);

        // 5: branch ignored in BUSY, then reset mid-op
        longop = 1;
        tick();
        longop = 0;
        tick();
        br = 1;
        settle();
        chk_ctl("busy_br_ignored", LONG);
        chk("busy_br_busy", busy, 1);
        tick();
        br = 0; reset = 1;
        settle();
        chk_ctl("rst_mid_ctl", DEF);
        chk("rst_mid_busy", busy, 0);
        tick();
        reset = 0;
        settle();
        chk_ctl("post_rst_ctl", DEF);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_stalls", stalls, 0);

        // 6: saturation on the PERF_W=4 instance, back-to-back long ops
        longop8 = 1;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_16", stalls8, 14);
        tick();
        chk("sat_17", stalls8, 15);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_20", stalls8, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_25", stalls8, 15);
        longop8 = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
